// File: rtl/led_pkg.sv
// Shared types and constants for the LED serial frame receiver.
// Optional feature macro used by the receiver: LED_RECEIVE_HDR_CHECK_EN.
package led_pkg;

  // Receiver frame states.
  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LED  = 2'd1,
    END  = 2'd2
  } rx_state_t;

  // The start frame is made of zero bits, the end frame of one bits.
  localparam logic [31:0] START_WORD = 32'h0;
  localparam logic [31:0] END_WORD   = 32'hFFFFFFFF;
  // Fixed marker expected in the top three bits of every LED word.
  localparam logic [2:0]  LED_HDR    = 3'b111;

  // Length of the zero run that arms the receiver for a new frame.
  localparam logic [5:0]  ZERO_RUN   = 6'd32;

  // True when an LED word carries the fixed header marker.
  function automatic logic hdr_ok(input logic [31:0] word);
    return word[31:29] == LED_HDR;
  endfunction

endpackage

// File: rtl/led_rx_sync.sv
// Brings cki/sdi into the clk domain and flags each cki rising edge.
// Both lines go through the same number of flops so that sdi_s is the data
// value that was present when cki rose, on the very cycle cki_rise is high.
module led_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic cki,
  input  logic sdi,
  output logic sdi_s,
  output logic cki_rise
);

  logic [SYNC_STAGES-1:0] cki_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic                   cki_prev;

  // Synchronizer chains plus the delayed cki copy used for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cki_sync <= '0;
      sdi_sync <= '0;
      cki_prev <= 1'b0;
    end else begin
      cki_sync <= {cki_sync[SYNC_STAGES-2:0], cki};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      cki_prev <= cki_sync[SYNC_STAGES-1];
    end
  end

  assign sdi_s    = sdi_sync[SYNC_STAGES-1];
  assign cki_rise = cki_sync[SYNC_STAGES-1] & ~cki_prev;

endmodule

// File: rtl/led_receive.sv
// Serial LED frame receiver: hunts for a 32-zero start frame, collects
// LED_NUM 32-bit LED words ({hdr,bright,blue,green,red}, MSB first), writes
// each word to a downstream pixel FIFO and checks the all-ones end frame.
// Words that arrive while the FIFO is full are dropped and flagged in ovf.
// Optional header check: define LED_RECEIVE_HDR_CHECK_EN to reject words
// whose top three bits are not 3'b111.
//
// Handshake: wr is a single-cycle write strobe with no back-pressure; a word
// is offered for exactly one cycle and is taken only if full is low in that
// cycle, otherwise it is lost and ovf is set.
module led_receive
  import led_pkg::*;
#(
  parameter int LED_NUM     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CNT = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cki,
  input  logic        sdi,
  input  logic        full,
  input  logic        ovf_clr,
  output logic        wr,
  output logic [23:0] wr_data,
  output logic [4:0]  wr_bright,
  output logic [7:0]  led_idx,
  output logic        frame_done,
  output logic        frame_err,
  output logic        ovf,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  localparam int          TW       = $clog2(TIMEOUT_CNT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CNT - 1);
  localparam logic [7:0]  LAST_IDX = 8'(LED_NUM - 1);

  logic          sdi_s;
  logic          cki_rise;

  rx_state_t     state;
  logic [5:0]    zero_cnt;
  logic [4:0]    bit_cnt;
  logic [30:0]   shift;
  logic [7:0]    word_idx;
  logic [TW-1:0] tmo_cnt;

  // Word waiting to be offered to the FIFO in the cycle after completion.
  logic          pend;
  logic [23:0]   pend_data;
  logic [4:0]    pend_bright;
  logic [7:0]    pend_idx;

  // Last word actually written; drives the outputs between strobes.
  logic [23:0]   hold_data;
  logic [4:0]    hold_bright;
  logic [7:0]    hold_idx;

  logic [31:0]   word_next;
  logic          last_bit;

  led_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rstn    (rstn),
    .cki     (cki),
    .sdi     (sdi),
    .sdi_s   (sdi_s),
    .cki_rise(cki_rise)
  );

  assign word_next = {shift, sdi_s};
  assign last_bit  = (bit_cnt == 5'd31);

  // Frame state machine: start detection, word assembly, end check, timeout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= HUNT;
      zero_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      word_idx    <= '0;
      tmo_cnt     <= '0;
      pend        <= 1'b0;
      pend_data   <= '0;
      pend_bright <= '0;
      pend_idx    <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      pend       <= 1'b0;
      case (state)
        HUNT: begin
          tmo_cnt <= '0;
          if (cki_rise) begin
            if (sdi_s == START_WORD[0]) begin
              if (zero_cnt != ZERO_RUN) zero_cnt <= zero_cnt + 6'd1;
            end else if (zero_cnt == ZERO_RUN) begin
              // This 1 bit is already bit 31 of LED word 0.
              state    <= LED;
              bit_cnt  <= 5'd1;
              word_idx <= '0;
              shift    <= 31'd1;
              zero_cnt <= '0;
            end else begin
              zero_cnt <= '0;
            end
          end
        end

        LED, END: begin
          if (cki_rise) begin
            tmo_cnt <= '0;
            shift   <= word_next[30:0];
            bit_cnt <= bit_cnt + 5'd1;
            if (last_bit) begin
              if (state == LED) begin
`ifdef LED_RECEIVE_HDR_CHECK_EN
                if (!hdr_ok(word_next)) begin
                  frame_err <= 1'b1;
                  state     <= HUNT;
                  zero_cnt  <= '0;
                end else
`endif
                begin
                  pend        <= 1'b1;
                  pend_data   <= word_next[23:0];
                  pend_bright <= word_next[28:24];
                  pend_idx    <= word_idx;
                  if (word_idx == LAST_IDX) state <= END;
                  else word_idx <= word_idx + 8'd1;
                end
              end else begin
                if (word_next == END_WORD) frame_done <= 1'b1;
                else frame_err <= 1'b1;
                state    <= HUNT;
                zero_cnt <= '0;
              end
            end
          end else if (tmo_cnt == TMO_LAST) begin
            frame_err <= 1'b1;
            state     <= HUNT;
            zero_cnt  <= '0;
            tmo_cnt   <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        default: state <= HUNT;
      endcase
    end
  end

  assign wr = pend & ~full;

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf <= 1'b0;
    end else if (pend && full) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  // Capture each written word so the outputs hold until the next write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_data   <= '0;
      hold_bright <= '0;
      hold_idx    <= '0;
    end else if (wr) begin
      hold_data   <= pend_data;
      hold_bright <= pend_bright;
      hold_idx    <= pend_idx;
    end
  end

  assign wr_data   = wr ? pend_data   : hold_data;
  assign wr_bright = wr ? pend_bright : hold_bright;
  assign led_idx   = wr ? pend_idx    : hold_idx;
  assign busy      = (state != HUNT);
  assign state_dbg = state;

endmodule

// File: tb/tb_led_receive.sv
// Bench for led_receive: table of whole-frame vectors, randomized frames
// against a word-level reference model, and hand-written timeout / reset /
// short-start sequences.
`timescale 1ns/1ps
module tb_led_receive;

  localparam int LED_NUM = 4;

  typedef logic [LED_NUM-1:0][31:0] words_t;

  typedef struct {
    int          lead;
    words_t      w;
    logic [31:0] endw;
    int          fw;      // word index sent with full=1, -1 for none
    int          n_wr;
    int          n_done;
    int          n_err;
    logic        ovf;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic cki = 1'b0;
  logic sdi = 1'b0;
  logic full = 1'b0;
  logic ovf_clr = 1'b0;

  logic        wr;
  logic [23:0] wr_data;
  logic [4:0]  wr_bright;
  logic [7:0]  led_idx;
  logic        frame_done;
  logic        frame_err;
  logic        ovf;
  logic        busy;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  led_receive #(
    .LED_NUM(LED_NUM),
    .SYNC_STAGES(2),
    .TIMEOUT_CNT(64)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cki       (cki),
    .sdi       (sdi),
    .full      (full),
    .ovf_clr   (ovf_clr),
    .wr        (wr),
    .wr_data   (wr_data),
    .wr_bright (wr_bright),
    .led_idx   (led_idx),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .ovf       (ovf),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];
  logic [36:0] last_rec = '0;
  int n_wr = 0;
  int n_done = 0;
  int n_err = 0;
  logic prev_wr = 1'b0;
  logic prev_done = 1'b0;
  logic prev_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [36:0] rec;
    if (!rstn) begin
      prev_wr   = 1'b0;
      prev_done = 1'b0;
      prev_err  = 1'b0;
    end else begin
      if (wr) begin
        n_wr++;
        check("wr_one_cycle", 64'(prev_wr), 64'(0));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected actual=%0h expected=none", {led_idx, wr_bright, wr_data});
        end else begin
          rec = exp_q.pop_front();
          check("wr_word", 64'({led_idx, wr_bright, wr_data}), 64'(rec));
          last_rec = rec;
        end
      end
      if (frame_done) begin
        n_done++;
        check("done_one_cycle", 64'(prev_done), 64'(0));
      end
      if (frame_err) begin
        n_err++;
        check("err_one_cycle", 64'(prev_err), 64'(0));
      end
      prev_wr   = wr;
      prev_done = frame_done;
      prev_err  = frame_err;
    end
  end

  // Word-level reference: which words reach the FIFO and how the frame ends.
  task automatic model_frame(input words_t w, input logic [31:0] endw, input int fw,
                             output int e_wr, output int e_done, output int e_err,
                             output logic e_ovf);
    e_wr = 0; e_done = 0; e_err = 0; e_ovf = 1'b0;
    for (int i = 0; i < LED_NUM; i++) begin
`ifdef LED_RECEIVE_HDR_CHECK_EN
      if (w[i][31:29] != 3'b111) begin
        e_err = 1;
        return;
      end
`endif
      if (i == fw) begin
        e_ovf = 1'b1;
      end else begin
        exp_q.push_back({8'(i), w[i][28:24], w[i][23:0]});
        e_wr++;
      end
    end
    if (endw == 32'hFFFFFFFF) e_done = 1;
    else e_err = 1;
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_bit(input logic b);
    sdi = b;
    cki = 1'b0;
    tick(5);
    cki = 1'b1;
    tick(5);
  endtask

  task automatic send_word(input logic [31:0] word);
    for (int b = 31; b >= 0; b--) send_bit(word[b]);
  endtask

  task automatic send_frame(input int lead, input words_t w, input logic [31:0] endw, input int fw);
    repeat (lead) send_bit(1'b0);
    for (int i = 0; i < LED_NUM; i++) begin
      full = (i == fw);
      send_word(w[i]);
      full = 1'b0;
    end
    send_word(endw);
  endtask

  task automatic run_case(input string name, input vec_t v, input bit use_model);
    int b_wr, b_done, b_err;
    int e_wr, e_done, e_err;
    logic e_ovf;
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    b_wr = n_wr; b_done = n_done; b_err = n_err;
    model_frame(v.w, v.endw, v.fw, e_wr, e_done, e_err, e_ovf);
    if (!use_model) begin
      e_wr = v.n_wr; e_done = v.n_done; e_err = v.n_err; e_ovf = v.ovf;
    end
    send_frame(v.lead, v.w, v.endw, v.fw);
    tick(10);
    check({name, "_wr_count"}, 64'(n_wr - b_wr), 64'(e_wr));
    check({name, "_done_count"}, 64'(n_done - b_done), 64'(e_done));
    check({name, "_err_count"}, 64'(n_err - b_err), 64'(e_err));
    check({name, "_ovf"}, 64'(ovf), 64'(e_ovf));
    check({name, "_busy_idle"}, 64'(busy), 64'(0));
    check({name, "_exp_q_drained"}, 64'(exp_q.size()), 64'(0));
    if (e_wr > 0) check({name, "_hold"}, 64'({led_idx, wr_bright, wr_data}), 64'(last_rec));
  endtask

  // watchdog
  initial begin
    #900000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  vec_t   tbl[6];
  words_t base;
  words_t mod;

  initial begin
    int  b_wr, b_err;
    logic busy_seen;
    vec_t rv;

    base = {32'hE5445566, 32'hE5334455, 32'hE5223344, 32'hE5112233};
    mod = base;
    mod[1] = 32'h65000000;

    tbl[0] = '{32, base, 32'hFFFFFFFF, -1, 4, 1, 0, 1'b0};
    tbl[1] = '{40, base, 32'hFFFFFFFF, -1, 4, 1, 0, 1'b0};
    tbl[2] = '{32, base, 32'hFFFFFFFF,  2, 3, 1, 0, 1'b1};
    tbl[3] = '{32, base, 32'hFFFFFFFE, -1, 4, 0, 1, 1'b0};
`ifdef LED_RECEIVE_HDR_CHECK_EN
    tbl[4] = '{32, mod,  32'hFFFFFFFF, -1, 1, 0, 1, 1'b0};
`else
    tbl[4] = '{32, mod,  32'hFFFFFFFF, -1, 4, 1, 0, 1'b0};
`endif
    tbl[5] = '{35, {32'hFF000000, 32'hE0FFFFFF, 32'hF8000001, 32'hFFABCDEF},
               32'hFFFFFFFF, -1, 4, 1, 0, 1'b0};

    // reset state
    tick(3);
    check("rst_wr", 64'(wr), 64'(0));
    check("rst_wr_data", 64'(wr_data), 64'(0));
    check("rst_wr_bright", 64'(wr_bright), 64'(0));
    check("rst_led_idx", 64'(led_idx), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    check("rst_frame_err", 64'(frame_err), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    rstn = 1'b1;
    tick(3);

    // table-driven frames
    for (int i = 0; i < 6; i++) begin
      run_case($sformatf("vec%0d", i), tbl[i], 1'b0);
      if (i == 2) begin
        // ovf survives the frame until explicitly cleared
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        tick(1);
        check("ovf_clear", 64'(ovf), 64'(0));
      end
    end

    // 31 zeros then a 1 must not start a frame
    b_wr = n_wr;
    busy_seen = 1'b0;
    for (int i = 0; i < 31; i++) begin
      send_bit(1'b0);
      busy_seen |= busy;
    end
    for (int i = 0; i < 40; i++) begin
      send_bit(1'b1);
      busy_seen |= busy;
    end
    check("short_start_busy", 64'(busy_seen), 64'(0));
    check("short_start_wr", 64'(n_wr - b_wr), 64'(0));

    // cki stops after word 1: timeout aborts the frame
    b_wr = n_wr;
    b_err = n_err;
    exp_q.push_back({8'd0, base[0][28:24], base[0][23:0]});
    exp_q.push_back({8'd1, base[1][28:24], base[1][23:0]});
    repeat (32) send_bit(1'b0);
    send_word(base[0]);
    send_word(base[1]);
    tick(40);
    check("tmo_busy_before", 64'(busy), 64'(1));
    tick(40);
    check("tmo_err", 64'(n_err - b_err), 64'(1));
    check("tmo_busy", 64'(busy), 64'(0));
    check("tmo_wr", 64'(n_wr - b_wr), 64'(2));

    // reset mid-frame after word 1, then a clean frame
    exp_q.push_back({8'd0, base[0][28:24], base[0][23:0]});
    exp_q.push_back({8'd1, base[1][28:24], base[1][23:0]});
    repeat (32) send_bit(1'b0);
    send_word(base[0]);
    send_word(base[1]);
    rstn = 1'b0;
    tick(3);
    check("midrst_wr_data", 64'(wr_data), 64'(0));
    check("midrst_led_idx", 64'(led_idx), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    rstn = 1'b1;
    last_rec = '0;
    tick(3);
    check("midrst_exp_q", 64'(exp_q.size()), 64'(0));
    run_case("after_rst", tbl[0], 1'b0);

    // randomized frames against the reference model
    for (int k = 0; k < 7; k++) begin
      rv.lead = $urandom_range(32, 40);
      for (int i = 0; i < LED_NUM; i++)
        rv.w[i] = {3'b111, 5'($urandom), 24'($urandom)};
      rv.endw = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'hFFFFFFFF;
      rv.fw = $urandom_range(0, 5);
      rv.n_wr = 0; rv.n_done = 0; rv.n_err = 0; rv.ovf = 1'b0;
      run_case($sformatf("rand%0d", k), rv, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_receive.md
LED_RECEIVE -- requirements
Module: led_receive

Interface
REQ-001 The block SHALL have a parameter LED_NUM, default 4, giving the LED words per frame (1..255).
REQ-002 The block SHALL have a parameter SYNC_STAGES, default 2, giving the synchronizer depth for cki/sdi (2..3).
REQ-003 The block SHALL have a parameter TIMEOUT_CNT, default 64, giving the clk cycles without a cki rising edge that abort a frame.
REQ-004 The block SHALL have the port clk, input, 1 bit: system clock, at least 4x the cki frequency; rising-edge active.
REQ-005 The block SHALL have the port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have the port cki, input, 1 bit: serial clock from the LED transmitter, asynchronous to clk.
REQ-007 The block SHALL have the port sdi, input, 1 bit: serial data, MSB first, valid on cki rising edge.
REQ-008 The block SHALL have the port full, input, 1 bit: downstream pixel FIFO full.
REQ-009 The block SHALL have the port ovf_clr, input, 1 bit: synchronous clear of the ovf flag.
REQ-010 The block SHALL have the port wr, output, 1 bit: one-cycle pixel write strobe.
REQ-011 The block SHALL have the port wr_data, output, 24 bits: received {BLUE,GREEN,RED}.
REQ-012 The block SHALL have the port wr_bright, output, 5 bits: received brightness field.
REQ-013 The block SHALL have the port led_idx, output, 8 bits: index 0..LED_NUM-1 of the current wr_data.
REQ-014 The block SHALL have the port frame_done, output, 1 bit: one-cycle pulse on a valid end frame.
REQ-015 The block SHALL have the port frame_err, output, 1 bit: one-cycle pulse on a framing, header or timeout error.
REQ-016 The block SHALL have the port ovf, output, 1 bit: sticky flag, set when a word is dropped because full=1.
REQ-017 The block SHALL have the port busy, output, 1 bit: high whenever the state is not HUNT.

Function
REQ-018 cki and sdi SHALL each pass through SYNC_STAGES flops; a rising edge SHALL be detected when the synchronized cki goes from 0 to 1, and sdi SHALL be sampled on that same cycle.
REQ-019 The FSM SHALL have exactly these states: HUNT, LED, END.
REQ-020 In HUNT, a zero-run counter SHALL count consecutive 0 bits, saturate at 32, and reset to 0 on any 1 bit received while it is below 32.
REQ-021 In HUNT, a 1 bit received while the zero-run count is 32 SHALL be taken as bit 31 of LED word 0, and the FSM SHALL go to LED with bit_cnt=1 and led_idx=0.
REQ-022 In LED, every 32nd bit SHALL complete a word; on completion, wr SHALL pulse in the next clk cycle with wr_bright=word[28:24], wr_data=word[23:0], led_idx=word index.
REQ-023 If full=1 in the wr cycle, wr SHALL stay 0, the word SHALL be dropped, ovf SHALL be set, and reception SHALL continue.
REQ-024 After word LED_NUM-1 completes, the FSM SHALL go to END; the next 32 bits SHALL be compared against 32'hFFFFFFFF.
REQ-025 On an END match, frame_done SHALL pulse; on a mismatch, frame_err SHALL pulse; in both cases the FSM SHALL return to HUNT with the zero-run counter cleared.
REQ-026 In LED or END, TIMEOUT_CNT clk cycles without a detected edge SHALL pulse frame_err and return the FSM to HUNT; the timeout counter SHALL reset on every edge.
REQ-027 If ovf_clr and a drop event occur in the same cycle, ovf SHALL end at 1 (set wins).
REQ-028 wr_data, wr_bright and led_idx SHALL hold their values between wr pulses.
REQ-029 wr, frame_done and frame_err SHALL never be high for more than one consecutive cycle.

Reset
REQ-030 While rstn=0, the block SHALL force: state=HUNT; all counters, shift register and sync flops = 0; wr, wr_data, wr_bright, led_idx, frame_done, frame_err, ovf, busy = 0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; after release, the block SHALL require a fresh 32-zero start frame.

Configuration
REQ-032 With LED_RECEIVE_HDR_CHECK_EN defined, a completed LED word whose bits[31:29] are not 3'b111 SHALL suppress wr, pulse frame_err, and return the FSM to HUNT.
REQ-033 Without LED_RECEIVE_HDR_CHECK_EN, bits[31:29] SHALL be ignored and every completed word SHALL be written.

Structure
REQ-034 Package led_pkg SHALL contain the rx_state_t enum (HUNT, LED, END) and the constants START_WORD=32'h0, END_WORD=32'hFFFFFFFF and LED_HDR=3'b111.
REQ-035 Sub-module led_rx_sync SHALL hold the SYNC_STAGES synchronizers plus the cki rising-edge detector and output sdi_s and cki_rise.

Verification
REQ-036 Frame 32x0, then 4 words 0xE5_112233..0xE5_445566, then 0xFFFFFFFF (cki=clk/10) -> 4 wr pulses, led_idx 0..3, wr_bright=5'h05, data in order, then 1 frame_done.
REQ-037 40 leading zeros, then a valid frame -> identical result; 31 leading zeros then 1 -> no wr, busy stays 0.
REQ-038 full=1 during word 2 -> 3 wr pulses (idx 0,1,3), ovf=1, frame_done=1; then ovf_clr -> ovf=0.
REQ-039 End word 0xFFFFFFFE -> frame_err pulse, no frame_done; cki stopped for 64 clk cycles after word 1 -> frame_err, busy=0.
REQ-040 With LED_RECEIVE_HDR_CHECK_EN, word 1 = 0x65_000000 -> frame_err, only idx 0 written; without the macro -> all 4 written.
REQ-041 rstn pulsed low after word 1, then a full valid frame -> no stale wr, 4 correct wr pulses, frame_done.
